// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Purpose : bundles the I-cache, D-cache and external memory signals that meet
//           at the shared memory-port arbiter.
// Ports   : no ports; parameters ADDR_W (byte-address width) and DATA_W
//           (word width).
// Modports:
//   slave  - the arbiter's view: requests, addresses, write data and memory
//            responses are inputs; grant-side data, strobes and memory beat
//            controls are outputs.
//   master - the view of the agents around the arbiter (caches, memory,
//            testbench), with every direction reversed.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // I-cache side
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_done;
    // D-cache side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_wnext;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_done;
    // External memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    // Hazard unit
    logic              stall;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
               mem_req, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_rdata, i_rvalid, i_done, d_wnext, d_rdata, d_rvalid, d_done,
               mem_req, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Purpose : shares one external memory port between I-cache refills and
//           D-cache refills / dirty write-backs. One requester is granted at a
//           time and a LINE_WORDS-beat burst is sequenced on the memory port.
//           Also produces the pipeline stall (CacheMiss) for the hazard unit.
// Ports   :
//   Clk  - clock, rising edge
//   Rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: I-cache request/refill, D-cache
//          request/refill/write-back, memory beat handshake and stall.
// Notes   :
//   Read data and beat strobes (x_rvalid, d_wnext) are combinational from
//   mem_ack so the caches see them in the same cycle the memory completes.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int            OFF       = $clog2(LINE_WORDS);
    localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_XFER_I = 3'd1,
        ST_XFER_D = 3'd2,
        ST_DONE_I = 3'd3,
        ST_DONE_D = 3'd4
    } state_t;

    state_t            r_state;
    logic [OFF-1:0]    r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic              r_we;
    logic              r_last_d;

    state_t            w_state_nxt;
    logic [OFF-1:0]    w_cnt_nxt;
    logic [ADDR_W-1:0] w_base_nxt;
    logic              w_we_nxt;
    logic              w_last_d_nxt;

    logic              w_grant_d;
    logic [ADDR_W-1:0] w_line_i;
    logic [ADDR_W-1:0] w_line_d;
    logic [ADDR_W-1:0] w_beat_addr;
    logic              w_unused_addr_bits;

    // Line-aligned base addresses: drop word offset and byte offset bits.
    assign w_line_i = {bus.i_addr[ADDR_W-1:OFF+2], {(OFF+2){1'b0}}};
    assign w_line_d = {bus.d_addr[ADDR_W-1:OFF+2], {(OFF+2){1'b0}}};
    assign w_unused_addr_bits = ^{bus.i_addr[OFF+1:0], bus.d_addr[OFF+1:0]};

    // D wins a tie unless it also won the previous grant, so neither side starves.
    assign w_grant_d = bus.d_req & (~bus.i_req | ~r_last_d);

    assign w_beat_addr = r_base | (ADDR_W'(r_cnt) << 2);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_base   <= '0;
            r_we     <= 1'b0;
            r_last_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_base   <= w_base_nxt;
            r_we     <= w_we_nxt;
            r_last_d <= w_last_d_nxt;
        end
    end

    // Next-state: arbitration in IDLE, beat counting during a burst.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_base_nxt   = r_base;
        w_we_nxt     = r_we;
        w_last_d_nxt = r_last_d;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt  = ST_XFER_D;
                    w_base_nxt   = w_line_d;
                    w_we_nxt     = bus.d_we;
                    w_cnt_nxt    = '0;
                    w_last_d_nxt = 1'b1;
                end else if (bus.i_req) begin
                    w_state_nxt  = ST_XFER_I;
                    w_base_nxt   = w_line_i;
                    w_we_nxt     = 1'b0;
                    w_cnt_nxt    = '0;
                    w_last_d_nxt = 1'b0;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_XFER_I, ST_XFER_D: begin
                // Burst cannot be aborted: request levels are ignored here.
                if (bus.mem_ack) begin
                    w_cnt_nxt = r_cnt + OFF'(1'b1);
                    if (r_cnt == LAST_BEAT) begin
                        w_state_nxt = (r_state == ST_XFER_I) ? ST_DONE_I : ST_DONE_D;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_DONE_I, ST_DONE_D: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: memory beat controls, cache strobes, done pulses, stall.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_rdata   = '0;
        bus.i_rvalid  = 1'b0;
        bus.i_done    = 1'b0;
        bus.d_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_wnext   = 1'b0;
        bus.d_done    = 1'b0;
        case (r_state)
            ST_XFER_I: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = w_beat_addr;
                if (bus.mem_ack) begin
                    bus.i_rvalid = 1'b1;
                    bus.i_rdata  = bus.mem_rdata;
                end else begin
                    bus.i_rvalid = 1'b0;
                end
            end
            ST_XFER_D: begin
                bus.mem_req  = 1'b1;
                bus.mem_we   = r_we;
                bus.mem_addr = w_beat_addr;
                if (r_we) begin
                    bus.mem_wdata = bus.d_wdata;
                    bus.d_wnext   = bus.mem_ack;
                end else if (bus.mem_ack) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = bus.mem_rdata;
                end else begin
                    bus.d_rvalid = 1'b0;
                end
            end
            ST_DONE_I: begin
                bus.i_done = 1'b1;
            end
            ST_DONE_D: begin
                bus.d_done = 1'b1;
            end
            default: begin
                bus.mem_req = 1'b0;
            end
        endcase
        // Release the pipeline in the done cycle so it resumes one cycle early.
        if ((r_state == ST_DONE_I) || (r_state == ST_DONE_D)) begin
            bus.stall = 1'b0;
        end else begin
            bus.stall = bus.i_req | bus.d_req | (r_state != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Purpose : directed self-checking bench for mem_port_arbiter. Inputs are
//           driven just after the falling edge, outputs checked 1 ns later,
//           always well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    logic Clk;
    logic Rst;
    int   n_vec;
    int   n_err;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // 100 MHz clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full line transfer starting in the first XFER cycle.
    // waits = number of cycles mem_ack stays low before each acked beat.
    task automatic run_line(input bit is_d, input bit we, input logic [31:0] base, input int waits);
        logic [31:0] exp_addr;
        for (int b = 0; b < 4; b++) begin
            exp_addr = base + 32'(4 * b);
            for (int w = 0; w < waits; w++) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'hFFFF_FFFF;
                #1;
                check("wait_req",   32'(bus.mem_req), 32'd1);
                check("wait_addr",  bus.mem_addr, exp_addr);
                check("wait_stall", 32'(bus.stall), 32'd1);
                check("wait_strobe", 32'(bus.i_rvalid | bus.d_rvalid | bus.d_wnext), 32'd0);
                @(negedge Clk);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = exp_addr ^ 32'hC0DE_0000;
            bus.d_wdata   = 32'hBEEF_0000 + 32'(b);
            #1;
            check("beat_req",   32'(bus.mem_req), 32'd1);
            check("beat_addr",  bus.mem_addr, exp_addr);
            check("beat_we",    32'(bus.mem_we), 32'(we));
            check("beat_stall", 32'(bus.stall), 32'd1);
            if (we) begin
                check("wb_wdata",  bus.mem_wdata, 32'hBEEF_0000 + 32'(b));
                check("wb_wnext",  32'(bus.d_wnext), 32'd1);
                check("wb_rvalid", 32'(bus.i_rvalid | bus.d_rvalid), 32'd0);
            end else if (is_d) begin
                check("d_rvalid", 32'(bus.d_rvalid), 32'd1);
                check("d_rdata",  bus.d_rdata, exp_addr ^ 32'hC0DE_0000);
                check("d_other",  32'(bus.i_rvalid | bus.d_wnext), 32'd0);
            end else begin
                check("i_rvalid", 32'(bus.i_rvalid), 32'd1);
                check("i_rdata",  bus.i_rdata, exp_addr ^ 32'hC0DE_0000);
                check("i_other",  32'(bus.d_rvalid | bus.d_wnext), 32'd0);
            end
            @(negedge Clk);
        end
        // Done cycle; mem_ack held high to show it is ignored without mem_req.
        bus.mem_ack = 1'b1;
        #1;
        check("done_own",    32'(is_d ? bus.d_done : bus.i_done), 32'd1);
        check("done_other",  32'(is_d ? bus.i_done : bus.d_done), 32'd0);
        check("done_stall",  32'(bus.stall), 32'd0);
        check("done_memreq", 32'(bus.mem_req), 32'd0);
        check("done_strobe", 32'(bus.i_rvalid | bus.d_rvalid | bus.d_wnext), 32'd0);
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(negedge Clk);
        #1;
        check("rst_stall",   32'(bus.stall), 32'd0);
        check("rst_memreq",  32'(bus.mem_req), 32'd0);
        check("rst_memaddr", bus.mem_addr, 32'd0);
        check("rst_done",    32'(bus.i_done | bus.d_done), 32'd0);
        Rst = 1'b0;

        // Stray ack in IDLE produces nothing.
        @(negedge Clk);
        bus.mem_ack = 1'b1;
        #1;
        check("idle_ack_strobe", 32'(bus.i_rvalid | bus.d_rvalid | bus.d_wnext), 32'd0);
        check("idle_ack_req",    32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;

        // I refill at 0x1234 -> line 0x1230, ack every cycle.
        @(negedge Clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_1234;
        #1;
        check("i_grant_stall",  32'(bus.stall), 32'd1);
        check("i_grant_memreq", 32'(bus.mem_req), 32'd0);
        @(negedge Clk);
        run_line(1'b0, 1'b0, 32'h0000_1230, 0);
        #1;
        check("i_idle_stall", 32'(bus.stall), 32'd0);
        check("i_idle_done",  32'(bus.i_done), 32'd0);

        // D write-back at 0x40.
        @(negedge Clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0040;
        #1;
        check("wb_grant_stall", 32'(bus.stall), 32'd1);
        @(negedge Clk);
        run_line(1'b1, 1'b1, 32'h0000_0040, 0);
        #1;
        check("wb_idle_req", 32'(bus.mem_req), 32'd0);

        // Both request together with last_d=0 after the write-back? last_d=1
        // here, so first clear it with an I-only transfer at 0x2000.
        @(negedge Clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_2004;
        @(negedge Clk);
        run_line(1'b0, 1'b0, 32'h0000_2000, 0);

        // Both together: D (0x80 refill) first, then I (0x200) even though
        // d_req is raised again in the idle cycle between them.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0200;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0088;
        #1;
        check("both_stall", 32'(bus.stall), 32'd1);
        @(negedge Clk);
        run_line(1'b1, 1'b0, 32'h0000_0080, 0);
        bus.d_req = 1'b1;
        #1;
        check("rearb_stall",  32'(bus.stall), 32'd1);
        check("rearb_memreq", 32'(bus.mem_req), 32'd0);
        @(negedge Clk);
        run_line(1'b0, 1'b0, 32'h0000_0200, 0);
        bus.d_req = 1'b0;
        #1;
        check("both_idle_stall", 32'(bus.stall), 32'd0);

        // Wait states: 3 low cycles before each ack, I refill at 0x3008.
        @(negedge Clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_3008;
        @(negedge Clk);
        run_line(1'b0, 1'b0, 32'h0000_3000, 3);

        // Reset in the middle of a burst (cnt = 2).
        @(negedge Clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0500;
        @(negedge Clk);
        bus.mem_ack = 1'b1;
        #1;
        check("mid_addr0", bus.mem_addr, 32'h0000_0500);
        @(negedge Clk);
        #1;
        check("mid_addr1", bus.mem_addr, 32'h0000_0504);
        @(negedge Clk);
        bus.mem_ack = 1'b0;
        #1;
        check("mid_addr2", bus.mem_addr, 32'h0000_0508);
        Rst = 1'b1; bus.i_req = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("mid_rst_memreq", 32'(bus.mem_req), 32'd0);
        check("mid_rst_stall",  32'(bus.stall), 32'd0);
        check("mid_rst_done",   32'(bus.i_done | bus.d_done), 32'd0);
        @(negedge Clk);
        #1;
        check("mid_rst_done2",  32'(bus.i_done | bus.d_done), 32'd0);

        // Fresh D refill restarts at beat 0 of line 0x600.
        @(negedge Clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_060C;
        @(negedge Clk);
        run_line(1'b1, 1'b0, 32'h0000_0600, 0);
        #1;
        check("end_stall", 32'(bus.stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
